pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline stage for the RV32 in-order core, used between any two stages (IF/ID, ID/EX, EX/MEM).
- Replaces the enable/flush style stage latch with a valid/ready handshake. An optional 2-entry skid buffer makes in_ready registered, which breaks the combinational stall path across stages.
- Supports synchronous flush (bubble insertion) and a saturating back-pressure cycle counter for performance debug.

Parameters:
- WIDTH, 32, payload width in bits (packed PC/imm/rs/rd/funct/flags bundle).
- NOP_VALUE, '0, payload value driven on bubbles, after reset and after flush.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  payload valid toward downstream.
- out_ready  in  1  downstream accepts; transfer occurs when out_valid && out_ready.
- out_data  out  WIDTH  payload toward downstream.
- level  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating.

Behaviour:
- Definitions: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Reset (async assert, sync release): state EMPTY, main = skid = NOP_VALUE, out_valid = 0, level = 0, stall_cnt = 0, in_ready = 1 (SKID_EN=1).
- States (SKID_EN=1): EMPTY (level 0), FULL (main valid, level 1), SKID (main+skid valid, level 2).
- out_valid = (state != EMPTY); out_data = main register.
- in_ready = (state != SKID). It is a registered decode of state and has no path from out_ready.
- EMPTY: in_fire -> FULL, main <= in_data. Otherwise stay.
- FULL, in_fire && out_fire -> FULL, main <= in_data.
- FULL, in_fire only -> SKID, skid <= in_data.
- FULL, out_fire only -> EMPTY, main <= NOP_VALUE.
- FULL, neither -> hold.
- SKID: out_fire -> FULL, main <= skid, skid <= NOP_VALUE. Otherwise hold. No input is accepted in SKID.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty.
- Ordering: strict FIFO order is required; no payload is ever duplicated or dropped except by flush.
- SKID_EN=0: single entry, state in {EMPTY, FULL}, in_ready = !out_valid || out_ready (combinational), level max 1. The skid register is not instantiated.
- Flush (highest priority after reset): next state EMPTY, main = skid = NOP_VALUE.
  - Any in_fire or out_fire in the flush cycle is honoured as a handshake, but the incoming payload is discarded.
  - in_ready in the flush cycle still follows current state.
- Flush with out_fire in the same cycle: downstream has consumed main; the stage still empties.
- stall_cnt: +1 each cycle out_valid && !out_ready, saturates at all-ones, not cleared by flush, cleared only by rst.
- Data transparency: payload bits pass unmodified; NOP_VALUE appears on out_data only when out_valid = 0.
- X handling: out_data must never be X after reset, even when in_data is X and in_valid = 0.

Decomposition:
- Shared package pipe_pkg: enum stage_state_e {ST_EMPTY, ST_FULL, ST_SKID} (2 bits), NOP payload constants per stage bundle, and the stage bundle field widths (REG_W=5, F7_W=7, F3_W=3, FLAGS_W=7, XLEN=32).
- One sub-module: sat_counter (parametrised CNT_W, inc, async rst) for stall_cnt.
- The skid-buffer logic stays inline.

Test Plan:
- Reset mid-operation: state SKID, data A/B; assert rst asynchronously -> same-cycle out_valid=0, out_data=NOP_VALUE, level=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, 8 back-to-back in_valid with payloads 0x100..0x107 -> out_valid from cycle 1, payloads emerge in order one per cycle, level stays 1, in_ready stays 1.
- Back-pressure: send A=0x11, B=0x22 with out_ready=0 -> level 2, in_ready=0, out_data=0x11, stall_cnt increments each cycle. Raise out_ready -> 0x11 then 0x22 delivered, level 2->1->0.
- Flush in SKID with in_valid=1 (C=0x33) and out_ready=0 -> next cycle out_valid=0, out_data=NOP_VALUE, level=0; A, B, C never appear downstream.
- Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt climbs to 15 and holds. A subsequent flush leaves it at 15.
- SKID_EN=0 build: out_ready toggling 1,0,1,0 with continuous input -> in_ready equals !out_valid || out_ready each cycle, level ≤1, no payload loss or duplication (scoreboard check).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage FSM encoding and RV32 stage bundle layout.
package pipe_pkg;
  localparam int XLEN    = 32;
  localparam int REG_W   = 5;
  localparam int F7_W    = 7;
  localparam int F3_W    = 3;
  localparam int FLAGS_W = 7;

  // Encoding doubles as the occupancy count driven on level.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  insn;
  } if_id_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic [F7_W-1:0]    funct7;
    logic [F3_W-1:0]    funct3;
    logic [FLAGS_W-1:0] flags;
  } id_ex_t;

  // IF/ID bubble carries a canonical addi x0,x0,0 so a decoder sees a real NOP.
  localparam if_id_t IF_ID_NOP = '{pc: '0, insn: 32'h0000_0013};
  localparam id_ex_t ID_EX_NOP = '0;
endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = XLEN,
  parameter logic [WIDTH-1:0]  NOP_VALUE = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] stall_cnt
);
  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign level     = state_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             in_ready_q;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
          ST_EMPTY: if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
          ST_FULL: begin
            if (in_fire && out_fire) begin
              main_d  = in_data;
            end else if (in_fire) begin
              state_d = ST_SKID;
              skid_d  = in_data;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
              main_d  = NOP_VALUE;
            end
          end
          ST_SKID: if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
          default: state_d = ST_EMPTY;
        endcase
        // Handshakes this cycle still complete; only the held payload is dropped.
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q    <= ST_EMPTY;
          main_q     <= NOP_VALUE;
          skid_q     <= NOP_VALUE;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          main_q     <= main_d;
          skid_q     <= skid_d;
          in_ready_q <= (state_d != ST_SKID);
        end
      end

      // Flopped so no combinational path from out_ready reaches upstream.
      assign in_ready = in_ready_q;
    end else begin : g_single
      assign in_ready = !out_valid || out_ready;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (in_fire) begin
          state_d = ST_FULL;
          main_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
        end
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = NOP_VALUE;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= ST_EMPTY;
          main_q  <= NOP_VALUE;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
        end
      end
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready),
    .cnt (stall_cnt)
  );
endmodule
